// File: rtl/btn_pkg.sv
// ---------------------------------------------------------------------------
// btn_pkg
//   Shared definitions for the button conditioner: per-channel FSM state
//   encoding, default timing constants for a 125 MHz system clock, and a
//   helper that yields the debounce counter's terminal value.
// ---------------------------------------------------------------------------
package btn_pkg;

    // Per-channel debounce FSM. The encoding is fixed because the AXI status
    // registers expose the raw state for diagnostics.
    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } btn_state_e;

    localparam int unsigned CLK_HZ              = 125_000_000;
    localparam int unsigned DEF_DEBOUNCE_CYC    = 1_250_000;    // 10 ms
    localparam int unsigned DEF_LONG_CYC        = 125_000_000;  // 1 s
    localparam int unsigned DEF_SYNC_STAGES     = 2;

    // A wait state is entered with dcnt already at 1, so the change is
    // accepted when dcnt reaches DEBOUNCE_CYC-1. For DEBOUNCE_CYC=1 that
    // value would be 0 and never match; clamp it to 1 so the change is
    // accepted one cycle after entering the wait state.
    function automatic int unsigned dcnt_accept_value(input int unsigned debounce_cyc);
        return (debounce_cyc > 1) ? (debounce_cyc - 1) : 1;
    endfunction

endpackage

// File: rtl/button_debounce_ch.sv
// ---------------------------------------------------------------------------
// button_debounce_ch
//   One button channel: multi-flop synchroniser, stable-time debounce FSM,
//   and hold-time counter for long-press detection. All outputs registered.
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous, active-high reset
//   pad_i      in   raw pad, already polarity-corrected (1 = pressed)
//   level_o    out  debounced level, 1 = pressed
//   press_o    out  1-cycle pulse when a press is accepted
//   release_o  out  1-cycle pulse when a release is accepted
//   long_o     out  1-cycle pulse once per press held LONG_CYC cycles
// ---------------------------------------------------------------------------
module button_debounce_ch
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int unsigned LONG_CYC     = DEF_LONG_CYC,
    parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic pad_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned LW = $clog2(LONG_CYC + 1);

    localparam logic [DW-1:0] D_ONE  = DW'(1);
    localparam logic [DW-1:0] D_LAST = DW'(dcnt_accept_value(DEBOUNCE_CYC));
    localparam logic [LW-1:0] L_ONE  = LW'(1);
    localparam logic [LW-1:0] L_LAST = LW'(LONG_CYC - 1);
    localparam logic [LW-1:0] L_MAX  = LW'(LONG_CYC);

    // ------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Debounce FSM and counters
    // ------------------------------------------------------------------
    btn_state_e    state_q, state_d;
    logic [DW-1:0] dcnt_q,  dcnt_d;
    logic [LW-1:0] lcnt_q,  lcnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          rel_q,   rel_d;
    logic          long_q,  long_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dcnt_q  <= '0;
            lcnt_q  <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            lcnt_q  <= lcnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            long_q  <= long_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        lcnt_d  = lcnt_q;
        level_d = level_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        long_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (s) begin
                    state_d = ST_PRESS_WAIT;
                    dcnt_d  = D_ONE;
                end
            end

            ST_PRESS_WAIT: begin
                if (!s) begin
                    // Glitch shorter than the debounce window: drop it.
                    state_d = ST_IDLE;
                    dcnt_d  = '0;
                end else if (dcnt_q == D_LAST) begin
                    state_d = ST_PRESSED;
                    dcnt_d  = '0;
                    lcnt_d  = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + D_ONE;
                end
            end

            ST_PRESSED: begin
                if (!s) begin
                    state_d = ST_RELEASE_WAIT;
                    dcnt_d  = D_ONE;
                end else if (lcnt_q != L_MAX) begin
                    // Saturating hold counter; the pulse fires only on the
                    // step into saturation, so at most once per press.
                    lcnt_d = lcnt_q + L_ONE;
                    long_d = (lcnt_q == L_LAST);
                end
            end

            ST_RELEASE_WAIT: begin
                if (s) begin
                    // Bounce while held: back to PRESSED, hold time frozen.
                    state_d = ST_PRESSED;
                    dcnt_d  = '0;
                end else if (dcnt_q == D_LAST) begin
                    state_d = ST_IDLE;
                    dcnt_d  = '0;
                    level_d = 1'b0;
                    rel_d   = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + D_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                dcnt_d  = '0;
            end
        endcase
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = rel_q;
    assign long_o    = long_q;

endmodule

// File: rtl/button_debounce_multi.sv
// ---------------------------------------------------------------------------
// button_debounce_multi
//   N-channel button conditioner. Each pad is polarity-corrected, then
//   synchronised and debounced independently; every channel produces a
//   debounced level and 1-cycle press / release / long-press pulses.
//
// Ports
//   clk          in   1      system clock
//   rst          in   1      asynchronous, active-high reset
//   btn_in       in   N_CH   raw asynchronous button pads
//   btn_level    out  N_CH   debounced state, 1 = pressed
//   btn_press    out  N_CH   1-cycle pulse on accepted press
//   btn_release  out  N_CH   1-cycle pulse on accepted release
//   btn_long     out  N_CH   1-cycle pulse once per press held LONG_CYC
// ---------------------------------------------------------------------------
module button_debounce_multi
    import btn_pkg::*;
#(
    parameter int unsigned N_CH         = 4,
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int unsigned LONG_CYC     = DEF_LONG_CYC,
    parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter bit          ACTIVE_LOW   = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release,
    output logic [N_CH-1:0] btn_long
);

    // Inversion sits in front of the first synchroniser flop so the
    // synchroniser's reset value of 0 always means "released".
    logic [N_CH-1:0] pad_pressed;

    always_comb begin
        pad_pressed = ACTIVE_LOW ? ~btn_in : btn_in;
    end

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        button_debounce_ch #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .LONG_CYC     (LONG_CYC),
            .SYNC_STAGES  (SYNC_STAGES)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .pad_i     (pad_pressed[ch]),
            .level_o   (btn_level[ch]),
            .press_o   (btn_press[ch]),
            .release_o (btn_release[ch]),
            .long_o    (btn_long[ch])
        );
    end

endmodule

// File: tb/tb_button_debounce_multi.sv
module tb_button_debounce_multi;

    localparam int unsigned NC   = 4;
    localparam int unsigned DC   = 8;
    localparam int unsigned LC   = 32;
    localparam int unsigned SS   = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NC-1:0] pads = '0;
    logic [NC-1:0] pads_n;
    logic [NC-1:0] lvl, prs, rel, lng;
    logic [NC-1:0] lvl_al, prs_al, rel_al, lng_al;

    assign pads_n = ~pads;

    always #5 clk = ~clk;

    button_debounce_multi #(
        .N_CH(NC), .DEBOUNCE_CYC(DC), .LONG_CYC(LC), .SYNC_STAGES(SS), .ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .btn_in(pads),
        .btn_level(lvl), .btn_press(prs), .btn_release(rel), .btn_long(lng)
    );

    // Same logical stimulus presented on active-low pads.
    button_debounce_multi #(
        .N_CH(NC), .DEBOUNCE_CYC(DC), .LONG_CYC(LC), .SYNC_STAGES(SS), .ACTIVE_LOW(1'b1)
    ) dut_al (
        .clk(clk), .rst(rst), .btn_in(pads_n),
        .btn_level(lvl_al), .btn_press(prs_al), .btn_release(rel_al), .btn_long(lng_al)
    );

    int errors = 0;
    int checks = 0;

    // ------------------------------------------------------------------
    // Behavioural model: a channel accepts a change once the synchronised
    // input has differed from the accepted level for DC consecutive
    // samples; hold time counts samples spent pressed with no pending
    // release, and the long pulse fires when it first reaches LC.
    // ------------------------------------------------------------------
    int            hist [NC][SS];
    int            acc  [NC];
    int            run  [NC];
    int            held [NC];
    logic [NC-1:0] e_lvl, e_prs, e_rel, e_lng;

    always @(posedge clk) begin
        e_prs = '0;
        e_rel = '0;
        e_lng = '0;
        for (int unsigned ch = 0; ch < NC; ch++) begin
            if (rst) begin
                for (int unsigned j = 0; j < SS; j++) hist[ch][j] = 0;
                acc[ch]  = 0;
                run[ch]  = 0;
                held[ch] = 0;
            end else begin
                int s;
                s = hist[ch][SS-1];
                for (int unsigned j = SS - 1; j > 0; j--) hist[ch][j] = hist[ch][j-1];
                hist[ch][0] = int'(pads[ch]);
                if (s != acc[ch]) begin
                    run[ch]++;
                    if (run[ch] == DC) begin
                        acc[ch] = s;
                        run[ch] = 0;
                        if (s == 1) begin
                            e_prs[ch] = 1'b1;
                            held[ch]  = 0;
                        end else begin
                            e_rel[ch] = 1'b1;
                        end
                    end
                end else begin
                    if (acc[ch] == 1 && run[ch] == 0 && held[ch] < LC) begin
                        held[ch]++;
                        if (held[ch] == LC) e_lng[ch] = 1'b1;
                    end
                    run[ch] = 0;
                end
            end
            e_lvl[ch] = (acc[ch] == 1);
        end

        #1;
        cmp("level",    lvl,    e_lvl);
        cmp("press",    prs,    e_prs);
        cmp("release",  rel,    e_rel);
        cmp("long",     lng,    e_lng);
        cmp("al_level", lvl_al, e_lvl);
        cmp("al_press", prs_al, e_prs);
        cmp("al_rel",   rel_al, e_rel);
        cmp("al_long",  lng_al, e_lng);
    end

    task automatic cmp(input string name, input logic [NC-1:0] act, input logic [NC-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Directed observation helpers
    // ------------------------------------------------------------------
    int cyc = 0;
    int wp [NC], wr [NC], wl [NC];
    int fp [NC], fr [NC], fl [NC];
    int fp_al;
    int other;
    int saw_all;

    task automatic clear_watch();
        for (int unsigned ch = 0; ch < NC; ch++) begin
            wp[ch] = 0; wr[ch] = 0; wl[ch] = 0;
            fp[ch] = -1; fr[ch] = -1; fl[ch] = -1;
        end
        fp_al   = -1;
        other   = 0;
        saw_all = 0;
    endtask

    task automatic watch(input int unsigned n);
        for (int unsigned c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (prs == 4'hF) saw_all = 1;
            if (prs_al[0] && fp_al < 0) fp_al = cyc;
            for (int unsigned ch = 0; ch < NC; ch++) begin
                if (prs[ch]) begin wp[ch]++; if (fp[ch] < 0) fp[ch] = cyc; end
                if (rel[ch]) begin wr[ch]++; if (fr[ch] < 0) fr[ch] = cyc; end
                if (lng[ch]) begin wl[ch]++; if (fl[ch] < 0) fl[ch] = cyc; end
                if (ch != 0 && (lvl[ch] || prs[ch] || rel[ch] || lng[ch])) other++;
            end
        end
    endtask

    task automatic drive(input int unsigned ch, input logic v);
        @(negedge clk);
        pads[ch] = v;
    endtask

    int mark;
    int hold [NC];
    int rst_cnt;

    initial begin
        clear_watch();

        // Reset state
        watch(3);
        chk("reset_outputs", int'({lvl, prs, rel, lng}), 0);
        chk("reset_outputs_al", int'({lvl_al, prs_al, rel_al, lng_al}), 0);
        @(negedge clk);
        rst = 1'b0;
        clear_watch();
        watch(6);
        chk("idle_after_reset_al", wp[0] + wp[1] + wp[2] + wp[3] + int'(lvl_al), 0);

        // ch0 held 20 cycles: press latency SYNC+DEBOUNCE
        clear_watch();
        drive(0, 1'b1);
        mark = cyc;
        watch(20);
        chk("press0_latency", fp[0] - mark, 10);
        chk("press0_count", wp[0], 1);
        chk("press0_latency_al", fp_al - mark, 10);
        chk("other_channels_quiet", other, 0);
        drive(0, 1'b0);
        mark = cyc;
        watch(20);
        chk("release0_latency", fr[0] - mark, 10);

        // ch1 glitch of 5 cycles rejected
        clear_watch();
        drive(1, 1'b1);
        watch(5);
        drive(1, 1'b0);
        watch(20);
        chk("glitch1_press", wp[1], 0);
        chk("glitch1_level", int'(lvl[1]), 0);

        // ch2 press, 3-cycle bounce, hold, release
        clear_watch();
        drive(2, 1'b1);
        watch(15);
        drive(2, 1'b0);
        watch(3);
        drive(2, 1'b1);
        watch(50);
        chk("bounce2_press", wp[2], 1);
        chk("bounce2_release", wr[2], 0);
        chk("bounce2_long", wl[2], 1);
        drive(2, 1'b0);
        mark = cyc;
        watch(20);
        chk("release2_latency", fr[2] - mark, 10);

        // ch3 long hold, short release gap, then real release
        clear_watch();
        drive(3, 1'b1);
        watch(100);
        chk("long3_after_press", fl[3] - fp[3], 32);
        chk("long3_count", wl[3], 1);
        drive(3, 1'b0);
        watch(6);
        drive(3, 1'b1);
        watch(10);
        chk("short_release3", wr[3], 0);
        drive(3, 1'b0);
        mark = cyc;
        watch(20);
        chk("release3_count", wr[3], 1);
        chk("release3_latency", fr[3] - mark, 10);
        chk("long3_once", wl[3], 1);

        // All channels together, then reset mid-press
        clear_watch();
        @(negedge clk);
        pads = 4'hF;
        watch(15);
        chk("press_all_same_cycle", saw_all, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", int'({lvl, prs, rel, lng}), 0);
        chk("async_reset_outputs_al", int'({lvl_al, prs_al, rel_al, lng_al}), 0);
        watch(3);
        @(negedge clk);
        rst = 1'b0;
        mark = cyc;
        clear_watch();
        watch(15);
        chk("repress0_after_reset", fp[0] - mark, 10);
        chk("repress3_after_reset", fp[3] - mark, 10);
        chk("repress_all_same_cycle", saw_all, 1);

        // Randomised phase, model-checked every cycle
        for (int unsigned ch = 0; ch < NC; ch++) hold[ch] = 0;
        rst_cnt = 0;
        for (int unsigned k = 0; k < 4000; k++) begin
            @(negedge clk);
            if (rst_cnt == 0 && $urandom_range(0, 699) == 0) rst_cnt = 3;
            if (rst_cnt > 0) begin
                rst = 1'b1;
                rst_cnt--;
            end else begin
                rst = 1'b0;
            end
            for (int unsigned ch = 0; ch < NC; ch++) begin
                if (hold[ch] == 0) begin
                    int r;
                    pads[ch] = ~pads[ch];
                    r = int'($urandom_range(0, 99));
                    if (r < 60)      hold[ch] = int'($urandom_range(1, 9));
                    else if (r < 90) hold[ch] = int'($urandom_range(8, 40));
                    else             hold[ch] = int'($urandom_range(40, 90));
                end else begin
                    hold[ch]--;
                end
            end
        end
        @(negedge clk);
        rst = 1'b0;
        pads = '0;
        watch(30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
